// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the program sequencer: the 3-bit opcode values
// understood by the datapath decoder, the sequencer FSM state encoding and a
// helper that says whether an opcode is a real datapath operation.
// No ports (package).
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam logic [2:0] OP_CLRLD = 3'b000;
    localparam logic [2:0] OP_ADDLD = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_DIV2  = 3'b011;
    localparam logic [2:0] OP_DISP  = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;
    localparam logic [2:0] OP_NOP2  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_WAIT_DISP = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Opcodes 000..100 drive the datapath; NOP encodings and HALT do not.
    function automatic logic is_valid_op(input logic [2:0] op);
        return (op <= OP_DISP);
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// ----------------------------------------------------------------------------
// seq_prog_mem
// DEPTH x 3-bit program register file. Synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives rst.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable (already qualified by the sequencer state)
//   waddr  in   AW-bit write address
//   wdata  in   3-bit opcode to store
//   raddr  in   AW-bit read address
//   rdata  out  3-bit opcode at raddr (combinational)
// ----------------------------------------------------------------------------
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [2:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [2:0]    rdata
);

    logic [2:0] mem [DEPTH];

    // Write port: one opcode per cycle when enabled, no reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so the sequencer can issue mem[pc] in the
    // same cycle pc points at it.
    assign rdata = mem[raddr];

endmodule

// File: rtl/seq_programa.sv
// ----------------------------------------------------------------------------
// seq_programa
// Program sequencer in front of the datapath instruction decoder. Holds a
// loadable program of 3-bit opcodes; on start it issues one opcode per cycle
// on instr_out, stalling after each DISP until the display acknowledges.
// Optional feature macro: SEQ_LOOP_EN (adds loop_cnt, repeats the program
// loop_cnt extra times without a bubble between passes).
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   prog_we     in   write prog_data to mem[prog_addr], honoured only in IDLE
//   prog_addr   in   AW-bit program write address
//   prog_data   in   3-bit opcode to store
//   prog_len    in   AW+1-bit entry count (0..DEPTH), sampled on start
//   start       in   begin execution, honoured only in IDLE
//   disp_ack    in   display consumed the current DISP (used in WAIT_DISP)
//   loop_cnt    in   4-bit extra pass count (SEQ_LOOP_EN only)
//   instr_out   out  opcode to decoder (NOP outside EXEC)
//   instr_valid out  instr_out is a real operation this cycle
//   busy        out  high in EXEC and WAIT_DISP
//   done        out  one-cycle pulse at program end
//   pc          out  current program index
// ----------------------------------------------------------------------------
module seq_programa
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          disp_ack,
`ifdef SEQ_LOOP_EN
    input  logic [3:0]    loop_cnt,
`endif
    output logic [2:0]    instr_out,
    output logic          instr_valid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    state_t      state;
    logic [AW:0] len;
    logic [AW:0] len_m1;
    logic [2:0]  mem_rd;
    logic        mem_we;
    logic        last_entry;
    logic        pass_end;
    logic        more_passes;

`ifdef SEQ_LOOP_EN
    logic [3:0]  passes;
    assign more_passes = (passes != 4'd0);
`else
    assign more_passes = 1'b0;
`endif

    // Loading is only allowed while idle so a running program never changes
    // underneath the sequencer.
    assign mem_we = prog_we && (state == ST_IDLE);

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (mem_rd)
    );

    // pc is compared in AW+1 bits so len==DEPTH ends at pc=DEPTH-1 without
    // pc ever having to wrap.
    assign len_m1     = len - (AW+1)'(1);
    assign last_entry = ({1'b0, pc} == len_m1);

    // A pass ends on HALT, on the last entry when it is not a DISP, or when
    // the display acknowledges a DISP sitting in the last entry.
    always_comb begin
        pass_end = 1'b0;
        if (state == ST_EXEC) begin
            pass_end = (mem_rd == OP_HALT) || ((mem_rd != OP_DISP) && last_entry);
        end else if (state == ST_WAIT_DISP) begin
            pass_end = disp_ack && last_entry;
        end
    end

    // Sequencer FSM with pc, length/pass bookkeeping and registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            len    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SEQ_LOOP_EN
            passes <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            if (pass_end) begin
                if (more_passes) begin
                    // Restart straight into EXEC so passes run back to back.
                    pc     <= '0;
                    state  <= ST_EXEC;
`ifdef SEQ_LOOP_EN
                    passes <= passes - 4'd1;
`endif
                end else begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            len    <= prog_len;
                            pc     <= '0;
`ifdef SEQ_LOOP_EN
                            passes <= loop_cnt;
`endif
                            if (prog_len == '0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_EXEC;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ST_EXEC: begin
                        // DISP parks pc on itself until the display answers.
                        if (mem_rd == OP_DISP) begin
                            state <= ST_WAIT_DISP;
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                    ST_WAIT_DISP: begin
                        if (disp_ack) begin
                            pc    <= pc + AW'(1);
                            state <= ST_EXEC;
                        end
                    end
                    ST_DONE: begin
                        pc    <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Only EXEC presents program memory to the decoder; every other state
    // shows a NOP so the decoder never acts on stale data.
    always_comb begin
        instr_out   = OP_NOP;
        instr_valid = 1'b0;
        if (state == ST_EXEC) begin
            instr_out   = mem_rd;
            instr_valid = is_valid_op(mem_rd);
        end
    end

endmodule

// File: tb/tb_seq_programa.sv
// ----------------------------------------------------------------------------
// tb_seq_programa
// Self-checking bench for seq_programa. Stimulus pushes expected events
// (issued opcode or done pulse, with the cycle it must appear in) into a
// queue; a monitor pops and compares whenever the DUT shows instr_valid or
// done. Directed checks cover idle/reset values and stall behaviour.
// The loop test is compiled only with SEQ_LOOP_EN.
// ----------------------------------------------------------------------------
module tb_seq_programa;

    typedef struct {
        bit         isDone;
        logic [2:0] op;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [2:0] prog_data;
    logic [4:0] prog_len;
    logic       start;
    logic       disp_ack;
`ifdef SEQ_LOOP_EN
    logic [3:0] loop_cnt;
`endif
    logic [2:0] instr_out;
    logic       instr_valid;
    logic       busy;
    logic       done;
    logic [3:0] pc;

    exp_t expQ[$];
    int   total;
    int   bad;
    int   cyc;
    bit   monitorOn;

    seq_programa #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .disp_ack    (disp_ack),
`ifdef SEQ_LOOP_EN
        .loop_cnt    (loop_cnt),
`endif
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
    );

    // Free-running clock and a cycle counter the expectations are keyed to.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic handleEvent(input bit isDone, input logic [2:0] op);
        exp_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: got %s op=%0b with nothing expected (cycle %0d)",
                     isDone ? "done" : "instr", op, cyc);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", int'({isDone, op}), int'({e.isDone, e.op}));
            checkOutput("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: sample on the falling edge, far from the active edge.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (instr_valid) handleEvent(1'b0, instr_out);
            if (done) handleEvent(1'b1, 3'b000);
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    function automatic int nextStart();
        return cyc + 1;
    endfunction

    task automatic expectInstr(input logic [2:0] op, input int at);
        exp_t e;
        e.isDone = 1'b0;
        e.op     = op;
        e.cyc    = at;
        expQ.push_back(e);
    endtask

    task automatic expectDone(input int at);
        exp_t e;
        e.isDone = 1'b1;
        e.op     = 3'b000;
        e.cyc    = at;
        expQ.push_back(e);
    endtask

    task automatic writeProg(input logic [3:0] addr, input logic [2:0] data);
        prog_addr = addr;
        prog_data = data;
        prog_we   = 1'b1;
        nextCycle();
        prog_we   = 1'b0;
    endtask

    // Pulse start for one cycle; returns inside the first cycle after start.
    task automatic applyStimulus(input logic [4:0] len);
        prog_len = len;
        start    = 1'b1;
        nextCycle();
        start    = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            nextCycle();
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles (cycle %0d)", budget, cyc);
        end
        nextCycle();
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_pc"}, int'(pc), 0);
        checkOutput({tag, "_instr"}, int'(instr_out), 5);
        checkOutput({tag, "_valid"}, int'(instr_valid), 0);
    endtask

    initial begin
        int s;
        total     = 0;
        bad       = 0;
        monitorOn = 1'b0;
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 3'b000;
        prog_len  = 5'd0;
        start     = 1'b0;
        disp_ack  = 1'b0;
`ifdef SEQ_LOOP_EN
        loop_cnt  = 4'd0;
`endif
        nextCycle();
        nextCycle();
        checkIdle("reset");
        checkOutput("reset_done", int'(done), 0);
        rst = 1'b0;
        monitorOn = 1'b1;
        nextCycle();

        $display("[TB] straight-line ADDLD,ADD,DIV2");
        writeProg(4'd0, 3'b001);
        writeProg(4'd1, 3'b010);
        writeProg(4'd2, 3'b011);
        s = nextStart();
        expectInstr(3'b001, s);
        expectInstr(3'b010, s + 1);
        expectInstr(3'b011, s + 2);
        expectDone(s + 3);
        applyStimulus(5'd3);
        checkOutput("run_busy", int'(busy), 1);
        waitDone(10);
        checkIdle("after_run");

        $display("[TB] DISP stall with late ack");
        writeProg(4'd0, 3'b000);
        writeProg(4'd1, 3'b100);
        writeProg(4'd2, 3'b010);
        s = nextStart();
        expectInstr(3'b000, s);
        expectInstr(3'b100, s + 1);
        expectInstr(3'b010, s + 7);
        expectDone(s + 8);
        applyStimulus(5'd3);
        nextCycle();
        disp_ack = 1'b1;
        nextCycle();
        disp_ack = 1'b0;
        checkOutput("wait_instr", int'(instr_out), 5);
        checkOutput("wait_busy", int'(busy), 1);
        checkOutput("wait_pc", int'(pc), 1);
        repeat (4) nextCycle();
        disp_ack = 1'b1;
        nextCycle();
        disp_ack = 1'b0;
        waitDone(10);

        $display("[TB] HALT ends early");
        writeProg(4'd0, 3'b010);
        writeProg(4'd1, 3'b111);
        writeProg(4'd2, 3'b010);
        s = nextStart();
        expectInstr(3'b010, s);
        expectDone(s + 2);
        applyStimulus(5'd3);
        nextCycle();
        checkOutput("halt_instr", int'(instr_out), 7);
        checkOutput("halt_valid", int'(instr_valid), 0);
        checkOutput("halt_pc", int'(pc), 1);
        waitDone(10);
        checkIdle("after_halt");

        $display("[TB] zero length");
        s = nextStart();
        expectDone(s);
        applyStimulus(5'd0);
        checkOutput("len0_busy", int'(busy), 0);
        waitDone(5);

        $display("[TB] start/prog_we ignored while busy and in DONE");
        writeProg(4'd0, 3'b010);
        writeProg(4'd1, 3'b010);
        writeProg(4'd2, 3'b010);
        writeProg(4'd3, 3'b010);
        s = nextStart();
        for (int i = 0; i < 4; i++) expectInstr(3'b010, s + i);
        expectDone(s + 4);
        applyStimulus(5'd4);
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 3'b111;
        nextCycle();
        start     = 1'b0;
        prog_we   = 1'b0;
        while (!done && cyc < s + 10) nextCycle();
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd2;
        prog_data = 3'b000;
        nextCycle();
        start     = 1'b0;
        prog_we   = 1'b0;
        nextCycle();
        checkIdle("ignored_start");
        s = nextStart();
        for (int i = 0; i < 4; i++) expectInstr(3'b010, s + i);
        expectDone(s + 4);
        applyStimulus(5'd4);
        waitDone(10);

        $display("[TB] reset mid-program");
        s = nextStart();
        for (int i = 0; i < 3; i++) expectInstr(3'b010, s + i);
        applyStimulus(5'd4);
        nextCycle();
        nextCycle();
        checkOutput("pre_rst_pc", int'(pc), 2);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkIdle("mid_rst");
        checkOutput("mid_rst_done", int'(done), 0);
        nextCycle();
        s = nextStart();
        for (int i = 0; i < 4; i++) expectInstr(3'b010, s + i);
        expectDone(s + 4);
        applyStimulus(5'd4);
        waitDone(10);

        $display("[TB] full depth, no wrap");
        for (int i = 0; i < 16; i++) writeProg(4'(i), 3'b001);
        s = nextStart();
        for (int i = 0; i < 16; i++) expectInstr(3'b001, s + i);
        expectDone(s + 16);
        applyStimulus(5'd16);
        repeat (15) nextCycle();
        checkOutput("full_last_pc", int'(pc), 15);
        waitDone(10);
        checkIdle("after_full");

`ifdef SEQ_LOOP_EN
        $display("[TB] loop passes");
        writeProg(4'd0, 3'b010);
        loop_cnt = 4'd2;
        s = nextStart();
        for (int i = 0; i < 3; i++) expectInstr(3'b010, s + i);
        expectDone(s + 3);
        applyStimulus(5'd1);
        loop_cnt = 4'd0;
        waitDone(10);
`endif

        repeat (3) nextCycle();
        checkOutput("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
